// File: rtl/al4s3b_wb_master_seq.sv
// ---------------------------------------------------------------------------
// al4s3b_wb_master_seq
//
// Wishbone initiator for the FPGA register blocks. Takes one command at a time
// from a valid/ready command stream and runs it as a single Wishbone classic
// read or write cycle. It then waits for ACK, giving up after TIMEOUT_CYCLES,
// and returns the read data and an error flag on a valid/ready response stream.
//
// Ports
//   WBs_CLK_i, WBs_RST_i      clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o   command handshake; ready is high only in IDLE
//   cmd_we_i/adr/dat/be       command payload (write enable, address, data, strobes)
//   rsp_valid_o/rsp_ready_i   response handshake
//   rsp_dat_o/rsp_err_o       read data (0 for writes and timeouts), timeout flag
//   WBm_*                     Wishbone master side, to the slave WBs_* port
//   busy_o                    high whenever the FSM is not IDLE
//   timeout_cnt_o             saturating count of aborted (timed-out) cycles
// ---------------------------------------------------------------------------
module al4s3b_wb_master_seq #(
    parameter int ADDRWIDTH      = 7,
    parameter int DATAWIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RST_i,

    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [ADDRWIDTH-1:0] cmd_adr_i,
    input  logic [DATAWIDTH-1:0] cmd_dat_i,
    input  logic [3:0]           cmd_be_i,

    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DATAWIDTH-1:0] rsp_dat_o,
    output logic                 rsp_err_o,

    output logic [ADDRWIDTH-1:0] WBm_ADR_o,
    output logic                 WBm_CYC_o,
    output logic                 WBm_STB_o,
    output logic                 WBm_WE_o,
    output logic [3:0]           WBm_BYTE_STB_o,
    output logic [DATAWIDTH-1:0] WBm_DAT_o,
    input  logic [DATAWIDTH-1:0] WBm_DAT_i,
    input  logic                 WBm_ACK_i,

    output logic                 busy_o,
    output logic [7:0]           timeout_cnt_o
);

    // Timer just needs to reach TIMEOUT_CYCLES-1.
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                 state_q,     state_d;
    logic [TW-1:0]          timer_q,     timer_d;
    logic                   cyc_q,       cyc_d;
    logic                   we_q,        we_d;
    logic [ADDRWIDTH-1:0]   adr_q,       adr_d;
    logic [DATAWIDTH-1:0]   wdat_q,      wdat_d;
    logic [3:0]             be_q,        be_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [DATAWIDTH-1:0]   rsp_dat_q,   rsp_dat_d;
    logic                   rsp_err_q,   rsp_err_d;
    logic [7:0]             to_cnt_q,    to_cnt_d;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        wdat_d      = wdat_q;
        be_d        = be_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        to_cnt_d    = to_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                // cmd_ready_o is high throughout IDLE, so valid alone accepts.
                if (cmd_valid_i) begin
                    cyc_d   = 1'b1;
                    we_d    = cmd_we_i;
                    adr_d   = cmd_adr_i;
                    wdat_d  = cmd_dat_i;
                    be_d    = cmd_be_i;
                    timer_d = '0;
                    state_d = S_BUS;
                end
            end

            S_BUS: begin
                // ACK is checked first so it wins over a same-cycle expiry.
                if (WBm_ACK_i) begin
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_dat_d   = we_q ? '0 : WBm_DAT_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else if (timer_q == TIMER_LAST) begin
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    if (to_cnt_q != 8'hFF) begin
                        to_cnt_d = to_cnt_q + 8'd1;
                    end
                    state_d     = S_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RST_i) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            wdat_q      <= '0;
            be_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            wdat_q      <= wdat_d;
            be_q        <= be_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign cmd_ready_o    = (state_q == S_IDLE);
    assign busy_o         = (state_q != S_IDLE);

    // CYC and STB come from one flop so they can never disagree.
    assign WBm_CYC_o      = cyc_q;
    assign WBm_STB_o      = cyc_q;
    assign WBm_WE_o       = we_q;
    assign WBm_ADR_o      = adr_q;
    assign WBm_DAT_o      = wdat_q;
    assign WBm_BYTE_STB_o = be_q;

    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_dat_o      = rsp_dat_q;
    assign rsp_err_o      = rsp_err_q;
    assign timeout_cnt_o  = to_cnt_q;

endmodule
